// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises A/B phases, decodes steps, keeps a wrapping up/down position count.
// Latency: an input change stable before edge k appears on count/step/err after edge k+SYNC_STAGES.
// Backpressure: none; each A/B state must be held >= 1 clk after synchronisation or it may alias as illegal.
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             err_flag
);

    // Decoding stays off until the synchronisers and prev register hold real samples.
    localparam int GUARD = SYNC_STAGES + 1;
    localparam int IW    = $clog2(GUARD + 1);

    logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
    logic [1:0]             prev_q, prev_d;
    logic [IW-1:0]          init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   step_q, step_d;
    logic                   dir_q, dir_d;
    logic                   err_q, err_d;
    logic                   err_flag_q, err_flag_d;

    logic [1:0] cur;
    logic       active;
    logic       up_tr;
    logic       dn_tr;
    logic       bad_tr;

    assign cur    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign active = (init_cnt_q == IW'(GUARD));

    // Synchroniser shift, prev tracking and saturating init-guard counter.
    always_comb begin
        a_sync_d   = {a_sync_q[SYNC_STAGES-2:0], a_in};
        b_sync_d   = {b_sync_q[SYNC_STAGES-2:0], b_in};
        prev_d     = cur;
        init_cnt_d = active ? init_cnt_q : init_cnt_q + IW'(1);
    end

    // Classify the prev -> cur transition; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        up_tr  = 1'b0;
        dn_tr  = 1'b0;
        bad_tr = 1'b0;
        case ({prev_q, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up_tr  = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dn_tr  = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: bad_tr = 1'b1;
            default: ;
        endcase
    end

    // Count/step/dir/err updates; clear overrides any same-cycle count change and the sticky flag.
    always_comb begin
        count_d    = count_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = 1'b0;
        err_flag_d = err_flag_q;
        if (active) begin
            if (bad_tr) begin
                err_d      = 1'b1;
                err_flag_d = 1'b1;
            end
            if (enable && up_tr) begin
                count_d = count_q + WIDTH'(1);
                dir_d   = 1'b1;
                step_d  = 1'b1;
            end else if (enable && dn_tr) begin
                count_d = count_q - WIDTH'(1);
                dir_d   = 1'b0;
                step_d  = 1'b1;
            end
        end
        if (clear) begin
            count_d    = '0;
            err_flag_d = 1'b0;
            step_d     = 1'b0;
            dir_d      = dir_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync_q   <= '0;
            b_sync_q   <= '0;
            prev_q     <= '0;
            init_cnt_q <= '0;
            count_q    <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            a_sync_q   <= a_sync_d;
            b_sync_q   <= b_sync_d;
            prev_q     <= prev_d;
            init_cnt_q <= init_cnt_d;
            count_q    <= count_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign count    = count_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign err      = err_q;
    assign err_flag = err_flag_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=8, SYNC_STAGES=2).
// Inputs are driven 1 ns after a rising edge; outputs are sampled at the same point.
// Table vectors hold each input state for a 4-cycle window and count pulses in it.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_in, b_in, enable, clear;
    logic [7:0] count;
    logic       step, dir, err, err_flag;

    int checks = 0;
    int errors = 0;

    quad_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .enable(enable), .clear(clear),
        .count(count), .step(step), .dir(dir), .err(err), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       b;
        logic       en;
        logic       clr;
        logic [7:0] exp_count;
        logic       exp_dir;
        logic       exp_ef;
        int         exp_steps;
        int         exp_errs;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance n edges, sampling 1 ns after each and accumulating pulses.
    task automatic run_win(input int n, output int steps, output int errs);
        steps = 0;
        errs  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            steps += int'(step);
            errs  += int'(err);
        end
    endtask

    task automatic apply(input logic a, input logic b, output int steps, output int errs);
        a_in = a;
        b_in = b;
        run_win(4, steps, errs);
    endtask

    int st, er;

    initial begin
        //                a  b  en clr count dir ef steps errs
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1,   1'b1, 1'b0, 1, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd2,   1'b1, 1'b0, 1, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd3,   1'b1, 1'b0, 1, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd4,   1'b1, 1'b0, 1, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd3,   1'b0, 1'b0, 1, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd4,   1'b1, 1'b0, 1, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1, 1'b0, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 1'b1, 0, 1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b1, 0, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1, 1'b0, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 0, 0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 0, 0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 0, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1,   1'b1, 1'b0, 1, 0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1,   1'b1, 1'b0, 0, 0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2,   1'b1, 1'b0, 1, 0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd2,   1'b1, 1'b1, 0, 1};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2,   1'b1, 1'b1, 0, 1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b1, 1'b0, 0, 0};

        // Static 11 held through reset: reset values, then silence after release.
        rst = 1'b1; a_in = 1'b1; b_in = 1'b1; enable = 1'b1; clear = 1'b0;
        #1;
        check("rst_count", int'(count), 0);
        check("rst_step", int'(step), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_flag", int'(err_flag), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_win(10, st, er);
        check("static11_steps", st, 0);
        check("static11_errs", er, 0);
        check("static11_count", int'(count), 0);
        check("static11_err_flag", int'(err_flag), 0);

        // Restart from 00 for the table.
        a_in = 1'b0; b_in = 1'b0; rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_win(6, st, er);
        check("idle00_count", int'(count), 0);

        for (int i = 0; i < 21; i++) begin
            enable = vecs[i].en;
            clear  = vecs[i].clr;
            apply(vecs[i].a, vecs[i].b, st, er);
            clear  = 1'b0;
            enable = 1'b1;
            check($sformatf("v%0d_count", i), int'(count), int'(vecs[i].exp_count));
            check($sformatf("v%0d_dir", i), int'(dir), int'(vecs[i].exp_dir));
            check($sformatf("v%0d_err_flag", i), int'(err_flag), int'(vecs[i].exp_ef));
            check($sformatf("v%0d_steps", i), st, vecs[i].exp_steps);
            check($sformatf("v%0d_errs", i), er, vecs[i].exp_errs);
        end

        // Latency: count moves on the third edge after a_in rises.
        a_in = 1'b1;
        @(posedge clk); #1;
        check("lat_edge1_count", int'(count), 0);
        @(posedge clk); #1;
        check("lat_edge2_count", int'(count), 0);
        @(posedge clk); #1;
        check("lat_edge3_count", int'(count), 1);
        check("lat_edge3_step", int'(step), 1);
        @(posedge clk); #1;
        check("lat_edge4_step", int'(step), 0);

        // Walk up to 5, then clear on the exact cycle the next up step is decoded.
        apply(1'b1, 1'b1, st, er);
        apply(1'b0, 1'b1, st, er);
        apply(1'b0, 1'b0, st, er);
        apply(1'b1, 1'b0, st, er);
        check("pre_clear_count", int'(count), 5);
        b_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_race_count", int'(count), 0);
        check("clr_race_step", int'(step), 0);
        check("clr_race_dir", int'(dir), 1);
        run_win(4, st, er);
        check("clr_race_late_steps", st, 0);
        check("clr_race_late_count", int'(count), 0);

        // Build nonzero state, then reset in the middle of a transition.
        apply(1'b0, 1'b1, st, er);
        check("pre_rst_count", int'(count), 1);
        apply(1'b1, 1'b0, st, er);
        check("pre_rst_err_flag", int'(err_flag), 1);
        a_in = 1'b0; b_in = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_dir", int'(dir), 0);
        check("mid_rst_step", int'(step), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_err_flag", int'(err_flag), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_win(10, st, er);
        check("post_rst_steps", st, 0);
        check("post_rst_errs", er, 0);
        check("post_rst_count", int'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
